// File: rtl/memory_access_pkg.sv
// Shared constants for the memory-access stage: write-back selects, RV32 load/store
// funct3 encodings and the stage FSM state encoding.
package memory_access_pkg;

    localparam logic [1:0] WB_ALU_OUT  = 2'd0;
    localparam logic [1:0] WB_MEM_DATA = 2'd1;
    localparam logic [1:0] WB_IMM      = 2'd2;
    localparam logic [1:0] WB_PC_NEXT  = 2'd3;

    localparam logic [2:0] MEM_LB  = 3'b000;
    localparam logic [2:0] MEM_LH  = 3'b001;
    localparam logic [2:0] MEM_LW  = 3'b010;
    localparam logic [2:0] MEM_LBU = 3'b100;
    localparam logic [2:0] MEM_LHU = 3'b101;
    localparam logic [2:0] MEM_SB  = 3'b000;
    localparam logic [2:0] MEM_SH  = 3'b001;
    localparam logic [2:0] MEM_SW  = 3'b010;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic op_is_invalid(input logic [2:0] op);
        return (op == 3'b011) || (op == 3'b110) || (op == 3'b111);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        logic half_access;
        half_access = (op == MEM_LH) || (op == MEM_LHU);
        return (half_access && addr_lo[0]) || ((op == MEM_LW) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/memory_access_if.sv
// Data-memory bus. Handshake: the stage holds dmem_req and all request fields stable
// until it samples dmem_ready=1 on a rising edge; that edge completes the transfer.
interface memory_access_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/load_store_align.sv
// Byte-lane steering: store byte enables and data replication, load lane select and
// sign/zero extension. Purely combinational.
module load_store_align
    import memory_access_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic        is_store,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        shifted   = rdata >> {addr_lo, 3'b000};
        byte_v    = shifted[7:0];
        half_v    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
        // Halfword lanes key off addr[1] only; addr[0] is don't-care here.
        case (op[1:0])
            2'b00: begin
                if (is_store) be = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = op[2] ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            end
            2'b01: begin
                if (is_store) be = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{store_data[15:0]}};
                load_data = op[2] ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage with IDLE/BUSY request FSM; state_dbg exposes the FSM.
// Optional MEM_MISALIGN_TRAP_EN traps misaligned halfword/word accesses without a bus request.
module memory_access
    import memory_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [2:0]  mem_op,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_data,
    input  logic [31:0] immediate,
    input  logic [31:0] pc_next,
    input  logic [1:0]  wb_sel,
    input  logic [4:0]  rd_in,
    input  logic        reg_we_in,
    output logic        stall,
    memory_access_if.master dmem,
    output logic        valid_out,
    output logic [1:0]  wb_sel_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] immediate_out,
    output logic [31:0] mem_data,
    output logic [31:0] pc_next_out,
    output logic [4:0]  rd_out,
    output logic        reg_we_out,
    output logic        misaligned_out,
    output state_t      state_dbg
);

    state_t      state_q, state_d;
    logic [31:0] lat_addr_q, lat_addr_d, lat_sdata_q, lat_sdata_d;
    logic [31:0] lat_imm_q, lat_imm_d, lat_pc_q, lat_pc_d;
    logic [2:0]  lat_op_q, lat_op_d;
    logic [1:0]  lat_wb_sel_q, lat_wb_sel_d;
    logic [4:0]  lat_rd_q, lat_rd_d;
    logic        lat_store_q, lat_store_d, lat_reg_we_q, lat_reg_we_d;

    logic        valid_out_q, valid_out_d, reg_we_out_q, reg_we_out_d;
    logic        misaligned_q, misaligned_d;
    logic [1:0]  wb_sel_out_q, wb_sel_out_d;
    logic [31:0] alu_result_out_q, alu_result_out_d, immediate_out_q, immediate_out_d;
    logic [31:0] mem_data_q, mem_data_d, pc_next_out_q, pc_next_out_d;
    logic [4:0]  rd_out_q, rd_out_d;

    logic        is_mem, misalign, trap, busy;
    logic [3:0]  align_be;
    logic [31:0] align_wdata, load_data;

    assign is_mem = mem_re | mem_we;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = is_mem && is_misaligned(mem_op, alu_result[1:0]);
`else
    assign misalign = 1'b0;
`endif
    assign trap = is_mem && (op_is_invalid(mem_op) || misalign);
    assign busy = (state_q == BUSY);

    load_store_align u_align (
        .op         (lat_op_q),
        .addr_lo    (lat_addr_q[1:0]),
        .is_store   (lat_store_q),
        .store_data (lat_sdata_q),
        .rdata      (dmem.dmem_rdata),
        .be         (align_be),
        .wdata      (align_wdata),
        .load_data  (load_data)
    );

    always_comb begin
        state_d          = state_q;
        lat_addr_d       = lat_addr_q;
        lat_sdata_d      = lat_sdata_q;
        lat_imm_d        = lat_imm_q;
        lat_pc_d         = lat_pc_q;
        lat_op_d         = lat_op_q;
        lat_wb_sel_d     = lat_wb_sel_q;
        lat_rd_d         = lat_rd_q;
        lat_store_d      = lat_store_q;
        lat_reg_we_d     = lat_reg_we_q;
        valid_out_d      = 1'b0;
        wb_sel_out_d     = wb_sel_out_q;
        alu_result_out_d = alu_result_out_q;
        immediate_out_d  = immediate_out_q;
        mem_data_d       = mem_data_q;
        pc_next_out_d    = pc_next_out_q;
        rd_out_d         = rd_out_q;
        reg_we_out_d     = reg_we_out_q;
        misaligned_d     = misaligned_q;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (is_mem && !trap) begin
                        state_d      = BUSY;
                        lat_addr_d   = alu_result;
                        lat_sdata_d  = rs2_data;
                        lat_imm_d    = immediate;
                        lat_pc_d     = pc_next;
                        lat_op_d     = mem_op;
                        lat_wb_sel_d = wb_sel;
                        lat_rd_d     = rd_in;
                        lat_store_d  = mem_we;
                        lat_reg_we_d = reg_we_in;
                    end else begin
                        valid_out_d      = 1'b1;
                        wb_sel_out_d     = wb_sel;
                        alu_result_out_d = alu_result;
                        immediate_out_d  = immediate;
                        pc_next_out_d    = pc_next;
                        rd_out_d         = rd_in;
                        reg_we_out_d     = reg_we_in & ~trap;
                        mem_data_d       = '0;
                        misaligned_d     = misalign;
                    end
                end
            end
            BUSY: begin
                // Read data is only ever sampled on the completing edge.
                if (dmem.dmem_ready) begin
                    state_d          = IDLE;
                    valid_out_d      = 1'b1;
                    wb_sel_out_d     = lat_wb_sel_q;
                    alu_result_out_d = lat_addr_q;
                    immediate_out_d  = lat_imm_q;
                    pc_next_out_d    = lat_pc_q;
                    rd_out_d         = lat_rd_q;
                    reg_we_out_d     = lat_reg_we_q;
                    mem_data_d       = lat_store_q ? '0 : load_data;
                    misaligned_d     = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            lat_addr_q       <= '0;
            lat_sdata_q      <= '0;
            lat_imm_q        <= '0;
            lat_pc_q         <= '0;
            lat_op_q         <= '0;
            lat_wb_sel_q     <= '0;
            lat_rd_q         <= '0;
            lat_store_q      <= 1'b0;
            lat_reg_we_q     <= 1'b0;
            valid_out_q      <= 1'b0;
            wb_sel_out_q     <= '0;
            alu_result_out_q <= '0;
            immediate_out_q  <= '0;
            mem_data_q       <= '0;
            pc_next_out_q    <= '0;
            rd_out_q         <= '0;
            reg_we_out_q     <= 1'b0;
            misaligned_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            lat_addr_q       <= lat_addr_d;
            lat_sdata_q      <= lat_sdata_d;
            lat_imm_q        <= lat_imm_d;
            lat_pc_q         <= lat_pc_d;
            lat_op_q         <= lat_op_d;
            lat_wb_sel_q     <= lat_wb_sel_d;
            lat_rd_q         <= lat_rd_d;
            lat_store_q      <= lat_store_d;
            lat_reg_we_q     <= lat_reg_we_d;
            valid_out_q      <= valid_out_d;
            wb_sel_out_q     <= wb_sel_out_d;
            alu_result_out_q <= alu_result_out_d;
            immediate_out_q  <= immediate_out_d;
            mem_data_q       <= mem_data_d;
            pc_next_out_q    <= pc_next_out_d;
            rd_out_q         <= rd_out_d;
            reg_we_out_q     <= reg_we_out_d;
            misaligned_q     <= misaligned_d;
        end
    end

    assign stall           = busy;
    assign state_dbg       = state_q;
    assign dmem.dmem_req   = busy;
    assign dmem.dmem_we    = busy & lat_store_q;
    assign dmem.dmem_addr  = busy ? {lat_addr_q[31:2], 2'b00} : '0;
    assign dmem.dmem_wdata = busy ? align_wdata : '0;
    assign dmem.dmem_be    = busy ? align_be : '0;

    assign valid_out      = valid_out_q;
    assign wb_sel_out     = wb_sel_out_q;
    assign alu_result_out = alu_result_out_q;
    assign immediate_out  = immediate_out_q;
    assign mem_data       = mem_data_q;
    assign pc_next_out    = pc_next_out_q;
    assign rd_out         = rd_out_q;
    assign reg_we_out     = reg_we_out_q;
    assign misaligned_out = misaligned_q;

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have inputs valid_in 1, mem_re 1, mem_we 1, mem_op 3 (RV32 funct3), alu_result 32 (address), rs2_data 32 (store data), immediate 32, pc_next 32, wb_sel 2, rd_in 5, reg_we_in 1; all from execute.
REQ-004 SHALL have output stall, 1 bit: upstream holds and does not present a new instruction while high.
REQ-005 SHALL have data-bus outputs dmem_req 1, dmem_we 1, dmem_addr 32, dmem_wdata 32, dmem_be 4, and inputs dmem_ready 1, dmem_rdata 32.
REQ-006 SHALL have registered outputs to write_back: valid_out 1, wb_sel_out 2, alu_result_out 32, immediate_out 32, mem_data 32, pc_next_out 32, rd_out 5, reg_we_out 1, misaligned_out 1.

Function
REQ-007 An instruction SHALL be accepted when valid_in=1 and stall=0; stall SHALL equal (state==BUSY).
REQ-008 FSM states SHALL be IDLE and BUSY; IDLE->BUSY on acceptance with mem_re|mem_we (and not trapped per REQ-019); BUSY->IDLE on dmem_ready=1; otherwise hold.
REQ-009 A non-memory instruction SHALL pass all fields to outputs one cycle after acceptance, valid_out=1, mem_data=0.
REQ-010 On entering BUSY, address, op, write data, byte enables and sideband fields SHALL be latched; dmem_req=1 and bus outputs SHALL be driven from the latch for every BUSY cycle.
REQ-011 In BUSY with dmem_ready=1, outputs SHALL update on that edge with valid_out=1; minimum memory latency is 2 cycles from acceptance.
REQ-012 valid_out SHALL be high for exactly one cycle per instruction and 0 in all other cycles, including while BUSY waits.
REQ-013 Stores: dmem_we=1; SB: be=1<<addr[1:0], wdata=byte replicated x4; SH: be=addr[1]?1100:0011, wdata=half replicated x2; SW: be=1111. dmem_addr SHALL be {addr[31:2],2'b00}.
REQ-014 Loads: dmem_we=0, be=1111; LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough, lane selected by latched addr[1:0].
REQ-015 mem_op 011/110/111 with mem_re|mem_we SHALL make no bus request, complete in one cycle, mem_data=0, reg_we_out=0.
REQ-016 mem_re and mem_we both high SHALL be treated as a store.
REQ-017 dmem_rdata SHALL be sampled only in the cycle where state==BUSY and dmem_ready=1; dmem_ready outside BUSY SHALL be ignored.

Reset
REQ-018 rst=1 SHALL immediately force state=IDLE, dmem_req=0, stall=0, and all registered outputs and latches to 0, aborting any BUSY transfer; the first acceptance is allowed on the first edge after rst falls.

Configuration
REQ-019 With MEM_MISALIGN_TRAP_EN defined: halfword access with addr[0]=1 or word access with addr[1:0]!=0 SHALL make no bus request, complete in one cycle with misaligned_out=1, reg_we_out=0, mem_data=0.
REQ-020 Without MEM_MISALIGN_TRAP_EN: misaligned_out SHALL be tied 0; halfword ignores addr[0], word ignores addr[1:0].

Structure
REQ-021 The shared package SHALL hold the mem_op constants (LB,LH,LW,LBU,LHU,SB,SH,SW) and the FSM state encoding, alongside the existing WB_SEL constants.
REQ-022 Lane selection and extension/replication SHALL be one combinational sub-module, load_store_align.

Verification
REQ-023 ALU op (wb_sel=ALU_OUT, alu_result=1, rd_in=5, reg_we_in=1) -> next cycle valid_out=1, alu_result_out=1, rd_out=5, stall never high.
REQ-024 SB addr=0x103, rs2_data=0x000000AB, dmem_ready after 3 BUSY cycles -> be=1000, wdata=0xABABABAB, addr=0x100, stall high 3 cycles, one valid_out pulse.
REQ-025 LB addr=0x202, dmem_rdata=0x0080FF00, ready first BUSY cycle -> mem_data=0xFFFFFF80; LBU same -> 0x00000080; LH addr=0x202 -> 0x00000080.
REQ-026 LW addr=0x300, rst pulsed in 2nd BUSY cycle -> dmem_req drops same cycle, no valid_out, next ALU op accepted normally.
REQ-027 With MEM_MISALIGN_TRAP_EN: LW addr=0x302 -> no dmem_req, misaligned_out=1, reg_we_out=0; without: dmem_addr=0x300, full word returned.
REQ-028 Back-to-back LW then ALU op -> ALU op held by stall, outputs appear in order, each valid_out one cycle.
